// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data RAM between the pipeline (priority) and a DMA/debug port.
// Optional fairness (starvation counter with a forced DMA grant) is enabled by defining DRAM_ARB_FAIRNESS_EN.
module dram_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [31:0]       p_addr,
  input  logic [31:0]       p_wdata,
  output logic [31:0]       p_rdata,
  output logic              p_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wre,
  input  logic [31:0]       ram_rdata,
  output logic [1:0]        arb_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, PIPE = 2'd1, DMA = 2'd2, FORCED = 2'd3} state_e;
  state_e            state_q, state_d;
  logic              force_sel, dma_sel;
  logic              d_rvalid_q, d_rvalid_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{p_addr[31:ADDR_W+2], p_addr[1:0]};
`ifdef DRAM_ARB_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;
  assign force_sel = (starve_q == LIMIT);
  // Count cycles D is denied by P, saturating at the limit; any DMA grant clears it.
  always_comb begin
    starve_d = dma_sel ? 4'd0 : (d_req & p_req & ~force_sel) ? starve_q + 4'd1 : starve_q;
  end
  // Starvation counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) starve_q <= 4'd0;
    else        starve_q <= starve_d;
  end
`else
  assign force_sel = 1'b0;
`endif
  assign dma_sel   = d_req & (~p_req | force_sel);
  assign d_gnt     = dma_sel;
  assign p_stall   = p_req & dma_sel;
  assign ram_addr  = dma_sel ? d_addr  : p_addr[ADDR_W+1:2];
  assign ram_wdata = dma_sel ? d_wdata : p_wdata;
  assign ram_wre   = dma_sel ? d_we    : (p_req & p_we);
  assign p_rdata   = (p_req & ~dma_sel) ? ram_rdata : 32'd0;
  // Next state and DMA read capture, both decided from this cycle's grant.
  always_comb begin
    state_d    = (dma_sel & p_req) ? FORCED : dma_sel ? DMA : p_req ? PIPE : IDLE;
    d_rvalid_d = dma_sel & ~d_we;
    d_rdata_d  = d_rvalid_d ? ram_rdata : d_rdata_q;
  end
  // State and read-response registers; reset drops any in-flight response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q  <= d_rdata_d;
    end
  end
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign arb_state = state_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: scoreboard bench for dram_arbiter with a behavioural async-read RAM.
module tb_dram_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        p_req = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0, p_rdata;
  logic        p_stall;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [6:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [6:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_wre;
  logic [1:0]  arb_state;
  logic [31:0] mem [128];
  logic [31:0] exp_q [$];
  int total = 0;
  int bad = 0;

  dram_arbiter #(.ADDR_W(7), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wre(ram_wre),
    .ram_rdata(ram_rdata), .arb_state(arb_state)
  );

  always #5 clock = ~clock;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clock) if (ram_wre) mem[ram_addr] <= ram_wdata;

  function automatic logic [31:0] init_val(int i);
    return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  // Scoreboard: every read response is matched against the oldest expected value.
  always @(negedge clock) begin
    if (reset && d_rvalid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: d_rvalid with d_rdata=%h, expected no response", d_rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (d_rdata !== e) begin
          bad++;
          $display("FAIL sb_rdata: got %h expected %h", d_rdata, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    total++; if (arb_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d expected 0", arb_state); end
    total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b expected 0", d_rvalid); end
    total++; if (d_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h expected 0", d_rdata); end
    d_req = 1; d_we = 0; d_addr = 7'd3;
    exp_q.push_back(init_val(3));
    cyc();
    d_req = 0;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== init_val(3)) begin bad++; $display("FAIL pre_rst_read: got %b/%h expected 1/%h", d_rvalid, d_rdata, init_val(3)); end
    total++; if (arb_state !== 2'd2) begin bad++; $display("FAIL pre_rst_state: got %0d expected 2", arb_state); end
    reset = 0;
    #1;
    exp_q.delete();
    total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL async_rst_rvalid: got %b expected 0", d_rvalid); end
    total++; if (d_rdata !== 32'd0) begin bad++; $display("FAIL async_rst_rdata: got %h expected 0", d_rdata); end
    total++; if (arb_state !== 2'd0) begin bad++; $display("FAIL async_rst_state: got %0d expected 0", arb_state); end
    cyc();
    reset = 1;
    cyc();
  endtask

  task automatic test_dma_write_read();
    p_req = 0; d_req = 1; d_we = 1; d_addr = 7'd5; d_wdata = 32'hDEADBEEF;
    #1;
    total++; if (d_gnt !== 1'b1 || ram_wre !== 1'b1 || ram_addr !== 7'd5) begin bad++; $display("FAIL dwr_grant: gnt=%b wre=%b addr=%0d expected 1/1/5", d_gnt, ram_wre, ram_addr); end
    total++; if (p_stall !== 1'b0) begin bad++; $display("FAIL dwr_stall: got %b expected 0", p_stall); end
    cyc();
    total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL dwr_noresp: got %b expected 0", d_rvalid); end
    d_we = 0;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    total++; if (d_gnt !== 1'b1 || ram_wre !== 1'b0) begin bad++; $display("FAIL drd_grant: gnt=%b wre=%b expected 1/0", d_gnt, ram_wre); end
    cyc();
    d_req = 0;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL drd_resp: got %b/%h expected 1/deadbeef", d_rvalid, d_rdata); end
    total++; if (arb_state !== 2'd2) begin bad++; $display("FAIL drd_state: got %0d expected 2", arb_state); end
    cyc();
    total++; if (d_rvalid !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL drd_hold: got %b/%h expected 0/deadbeef", d_rvalid, d_rdata); end
    total++; if (arb_state !== 2'd0) begin bad++; $display("FAIL idle_state: got %0d expected 0", arb_state); end
  endtask

  task automatic test_pipe_read();
    #1;
    total++; if (p_rdata !== 32'd0) begin bad++; $display("FAIL p_rdata_idle: got %h expected 0", p_rdata); end
    p_req = 1; p_we = 0; p_addr = 32'h14;
    #1;
    total++; if (ram_addr !== 7'd5 || ram_wre !== 1'b0) begin bad++; $display("FAIL prd_addr: addr=%0d wre=%b expected 5/0", ram_addr, ram_wre); end
    total++; if (p_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL prd_data: got %h expected deadbeef", p_rdata); end
    total++; if (p_stall !== 1'b0 || d_gnt !== 1'b0) begin bad++; $display("FAIL prd_stall: stall=%b gnt=%b expected 0/0", p_stall, d_gnt); end
    cyc();
    total++; if (arb_state !== 2'd1) begin bad++; $display("FAIL prd_state: got %0d expected 1", arb_state); end
    p_req = 0;
  endtask

  task automatic test_starvation();
    p_req = 1; p_we = 0; p_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 7'd5;
`ifdef DRAM_ARB_FAIRNESS_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (d_gnt !== 1'b0 || p_stall !== 1'b0) begin bad++; $display("FAIL starve_deny%0d: gnt=%b stall=%b expected 0/0", i, d_gnt, p_stall); end
      cyc();
      total++; if (arb_state !== 2'd1) begin bad++; $display("FAIL starve_state%0d: got %0d expected 1", i, arb_state); end
    end
    #1;
    total++; if (d_gnt !== 1'b1 || p_stall !== 1'b1 || ram_addr !== 7'd5) begin bad++; $display("FAIL force_gnt: gnt=%b stall=%b addr=%0d expected 1/1/5", d_gnt, p_stall, ram_addr); end
    total++; if (p_rdata !== 32'd0) begin bad++; $display("FAIL force_prdata: got %h expected 0", p_rdata); end
    exp_q.push_back(32'hDEADBEEF);
    cyc();
    d_req = 0;
    total++; if (arb_state !== 2'd3 || d_rvalid !== 1'b1) begin bad++; $display("FAIL force_state: state=%0d rvalid=%b expected 3/1", arb_state, d_rvalid); end
    #1;
    total++; if (p_stall !== 1'b0 || d_gnt !== 1'b0 || p_rdata !== init_val(8)) begin bad++; $display("FAIL after_force: stall=%b gnt=%b p_rdata=%h expected 0/0/%h", p_stall, d_gnt, p_rdata, init_val(8)); end
    cyc();
    total++; if (arb_state !== 2'd1) begin bad++; $display("FAIL after_force_state: got %0d expected 1", arb_state); end
`else
    for (int i = 0; i < 50; i++) begin
      #1;
      total++; if (d_gnt !== 1'b0 || p_stall !== 1'b0) begin bad++; $display("FAIL strict_deny%0d: gnt=%b stall=%b expected 0/0", i, d_gnt, p_stall); end
      cyc();
      total++; if (arb_state !== 2'd1) begin bad++; $display("FAIL strict_state%0d: got %0d expected 1", i, arb_state); end
    end
    p_req = 0;
    #1;
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL strict_release: got %b expected 1", d_gnt); end
    exp_q.push_back(32'hDEADBEEF);
    cyc();
    d_req = 0;
    total++; if (arb_state !== 2'd2) begin bad++; $display("FAIL strict_release_state: got %0d expected 2", arb_state); end
`endif
    p_req = 0;
    cyc();
  endtask

  task automatic test_conflict();
`ifdef DRAM_ARB_FAIRNESS_EN
    p_req = 1; p_we = 0; p_addr = 32'h0; d_req = 1; d_we = 1; d_addr = 7'd7; d_wdata = 32'h2;
    repeat (4) cyc();
    p_we = 1; p_addr = 32'h1C; p_wdata = 32'h1;
    #1;
    total++; if (d_gnt !== 1'b1 || p_stall !== 1'b1 || ram_wdata !== 32'h2) begin bad++; $display("FAIL conf_force: gnt=%b stall=%b wdata=%h expected 1/1/2", d_gnt, p_stall, ram_wdata); end
    cyc();
    d_req = 0;
    total++; if (mem[7] !== 32'h2) begin bad++; $display("FAIL conf_dwin: mem7=%h expected 2", mem[7]); end
    #1;
    total++; if (p_stall !== 1'b0 || ram_wre !== 1'b1 || ram_wdata !== 32'h1) begin bad++; $display("FAIL conf_pretry: stall=%b wre=%b wdata=%h expected 0/1/1", p_stall, ram_wre, ram_wdata); end
    cyc();
    total++; if (mem[7] !== 32'h1) begin bad++; $display("FAIL conf_plands: mem7=%h expected 1", mem[7]); end
`else
    p_req = 1; p_we = 1; p_addr = 32'h1C; p_wdata = 32'h1; d_req = 1; d_we = 1; d_addr = 7'd7; d_wdata = 32'h2;
    #1;
    total++; if (d_gnt !== 1'b0 || ram_wdata !== 32'h1) begin bad++; $display("FAIL conf_pwin: gnt=%b wdata=%h expected 0/1", d_gnt, ram_wdata); end
    cyc();
    total++; if (mem[7] !== 32'h1) begin bad++; $display("FAIL conf_plands: mem7=%h expected 1", mem[7]); end
    p_req = 0;
    cyc();
    d_req = 0;
    total++; if (mem[7] !== 32'h2) begin bad++; $display("FAIL conf_dlands: mem7=%h expected 2", mem[7]); end
`endif
    p_req = 0; p_we = 0; d_req = 0;
    cyc();
  endtask

  task automatic test_back_to_back();
    d_req = 1; d_we = 0;
    for (int i = 10; i < 16; i++) begin
      d_addr = 7'(i);
      exp_q.push_back(init_val(i));
      cyc();
      total++; if (d_rvalid !== 1'b1) begin bad++; $display("FAIL b2b_rvalid%0d: got %b expected 1", i, d_rvalid); end
    end
    d_req = 0;
    cyc();
    cyc();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_drain: %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = init_val(i);
    repeat (2) @(posedge clock);
    #1;
    reset = 1;
    cyc();
    test_reset();
    test_dma_write_read();
    test_pipe_read();
    test_starvation();
    test_conflict();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
